// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit for the
// single-bus datapath. Outputs are Moore decodes of the current state; only
// MDR_enable in memory-wait states also follows mem_ready.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds a 'step' input. When it is
// defined, each instruction starts only on a cycle with step=1.
// Memory handshake: a read/write strobe stays asserted in its wait state
// until mem_ready=1 in the same cycle, or until MEM_TIMEOUT cycles have
// elapsed without mem_ready, in which case the sequencer halts with mem_error.
module control_sequencer #(
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [4:0]  OPC_ADD     = 5'b00011,
  parameter logic [4:0]  OPC_AND     = 5'b00101,
  parameter logic [4:0]  OPC_OR      = 5'b00110
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] IR_Data,
  input  logic        mem_ready,
  output logic [15:0] reg_in_en,
  output logic [15:0] reg_out_sel,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        PC_select,
  output logic        HI_select,
  output logic        LO_select,
  output logic        Z_HI_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        InPort_select,
  output logic        c_select,
  output logic        read,
  output logic        write,
  output logic [4:0]  alu_instruction,
  output logic        halted,
  output logic        illegal_op,
  output logic        mem_error,
  output logic [3:0]  state_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_STEP_WAIT
  } state_t;

  state_t        state_q, state_d, fetch_tgt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Instruction fields and opcode classes
  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       is_r, is_i, is_md, is_nn, is_ld, is_st, is_nop, is_halt, is_legal;
  logic [4:0] imm_alu;
  logic       mem_wait, tmo_hit, ir_unused;

  assign opc       = IR_Data[31:27];
  assign ra        = IR_Data[26:23];
  assign rb        = IR_Data[22:19];
  assign rc        = IR_Data[18:15];
  assign ir_unused = ^IR_Data[14:0];
  assign is_r      = opc inside {[5'd3:5'd11]};
  assign is_i      = opc inside {5'd1, 5'd12, 5'd13, 5'd14};
  assign is_md     = opc inside {5'd15, 5'd16};
  assign is_nn     = opc inside {5'd17, 5'd18};
  assign is_ld     = (opc == 5'd0);
  assign is_st     = (opc == 5'd2);
  assign is_nop    = (opc == 5'd26);
  assign is_halt   = (opc == 5'd27);
  assign is_legal  = is_r | is_i | is_md | is_nn | is_ld | is_st | is_nop | is_halt;
  assign imm_alu   = (opc == 5'd13) ? OPC_AND : (opc == 5'd14) ? OPC_OR : OPC_ADD;

  // Wait states hold a strobe until mem_ready; the last allowed cycle is MEM_TIMEOUT-1
  assign mem_wait = (state_q == S_T1) || (state_q == S_T6 && is_ld) || (state_q == S_T7 && is_st);
  assign tmo_hit  = (cnt_q == CW'(MEM_TIMEOUT - 1));
  assign state_o  = state_q;
  assign mem_error = err_q;

`ifdef SEQ_SINGLE_STEP_EN
  assign fetch_tgt = step ? S_T0 : S_STEP_WAIT;
`else
  assign fetch_tgt = S_T0;
`endif

  // State, timeout counter and sticky error register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state: instruction sequencing plus memory-wait timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = err_q;
    if (mem_wait && !mem_ready) begin
      if (tmo_hit) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      case (state_q)
        S_IDLE:      if (run) state_d = fetch_tgt;
`ifdef SEQ_SINGLE_STEP_EN
        S_STEP_WAIT: if (step) state_d = S_T0;
`endif
        S_T0:        state_d = S_T1;
        S_T1:        state_d = S_T2;
        S_T2:        state_d = S_T3;
        S_T3:        state_d = is_halt ? S_HALT : (is_nop || !is_legal) ? fetch_tgt : S_T4;
        S_T4:        state_d = is_nn ? fetch_tgt : S_T5;
        S_T5:        state_d = (is_md || is_ld || is_st) ? S_T6 : fetch_tgt;
        S_T6:        state_d = (is_ld || is_st) ? S_T7 : fetch_tgt;
        S_T7:        state_d = fetch_tgt;
        S_HALT:      state_d = S_HALT;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Output decode of the current state (all zero by default)
  always_comb begin
    reg_in_en = '0; reg_out_sel = '0; alu_instruction = '0;
    PC_enable = 1'b0; PC_increment_enable = 1'b0; IR_enable = 1'b0; Y_enable = 1'b0;
    Z_enable = 1'b0; MAR_enable = 1'b0; MDR_enable = 1'b0; HI_enable = 1'b0; LO_enable = 1'b0;
    PC_select = 1'b0; HI_select = 1'b0; LO_select = 1'b0; Z_HI_select = 1'b0; Z_LO_select = 1'b0;
    MDR_select = 1'b0; InPort_select = 1'b0; c_select = 1'b0;
    read = 1'b0; write = 1'b0; halted = 1'b0; illegal_op = 1'b0;
    case (state_q)
      S_T0: begin PC_select = 1'b1; MAR_enable = 1'b1; PC_increment_enable = 1'b1; end
      S_T1: begin read = 1'b1; MDR_enable = mem_ready; end
      S_T2: begin MDR_select = 1'b1; IR_enable = 1'b1; end
      S_T3: begin
        if (is_nn) begin
          reg_out_sel = 16'h0001 << rb; alu_instruction = opc; Z_enable = 1'b1;
        end else if (is_md) begin
          reg_out_sel = 16'h0001 << ra; Y_enable = 1'b1;
        end else if (is_r || is_i || is_ld || is_st) begin
          reg_out_sel = 16'h0001 << rb; Y_enable = 1'b1;
        end else if (!is_legal) begin
          illegal_op = 1'b1;
        end
      end
      S_T4: begin
        if (is_nn) begin
          Z_LO_select = 1'b1; reg_in_en = 16'h0001 << ra;
        end else if (is_r || is_md) begin
          reg_out_sel = 16'h0001 << (is_r ? rc : rb); alu_instruction = opc; Z_enable = 1'b1;
        end else if (is_i) begin
          c_select = 1'b1; alu_instruction = imm_alu; Z_enable = 1'b1;
        end else if (is_ld || is_st) begin
          c_select = 1'b1; alu_instruction = OPC_ADD; Z_enable = 1'b1;
        end
      end
      S_T5: begin
        if (is_r || is_i) begin
          Z_LO_select = 1'b1; reg_in_en = 16'h0001 << ra;
        end else if (is_md) begin
          Z_LO_select = 1'b1; LO_enable = 1'b1;
        end else if (is_ld || is_st) begin
          Z_LO_select = 1'b1; MAR_enable = 1'b1;
        end
      end
      S_T6: begin
        if (is_md) begin
          Z_HI_select = 1'b1; HI_enable = 1'b1;
        end else if (is_ld) begin
          read = 1'b1; MDR_enable = mem_ready;
        end else if (is_st) begin
          reg_out_sel = 16'h0001 << ra; MDR_enable = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDR_select = 1'b1; reg_in_en = 16'h0001 << ra;
        end else if (is_st) begin
          write = 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized instruction stream for control_sequencer.
// A reference model expands each instruction into its per-cycle control
// outputs and input schedule; a driver replays the inputs and a separate
// monitor compares every cycle against the expected queue.
module tb_control_sequencer;

  localparam int         TO   = 16;
  localparam logic [4:0] ADD  = 5'b00011;
  localparam logic [4:0] ANDO = 5'b00101;
  localparam logic [4:0] ORO  = 5'b00110;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pc_en, pc_inc, ir_en, y_en, z_en, mar_en, mdr_en, hi_en, lo_en;
    logic pc_sel, hi_sel, lo_sel, zhi_sel, zlo_sel, mdr_sel, inp_sel, c_sel;
    logic rd, wr;
    logic [4:0] alu;
    logic halted, ill, merr;
  } out_t;
  localparam int W = $bits(out_t);

  // Clock / reset
  logic clk = 1'b0;
  logic clr, run, mem_ready;
  logic [31:0] IR_Data;
  always #5 clk = ~clk;

  logic [15:0] reg_in_en, reg_out_sel;
  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable;
  logic MDR_enable, HI_enable, LO_enable, PC_select, HI_select, LO_select;
  logic Z_HI_select, Z_LO_select, MDR_select, InPort_select, c_select;
  logic read, write, halted, illegal_op, mem_error;
  logic [4:0] alu_instruction;
  logic [3:0] state_o;
  out_t dut_o;

  control_sequencer dut (
    .clk(clk), .clr(clr), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
    .step(1'b1),
`endif
    .IR_Data(IR_Data), .mem_ready(mem_ready),
    .reg_in_en(reg_in_en), .reg_out_sel(reg_out_sel),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .HI_enable(HI_enable),
    .LO_enable(LO_enable), .PC_select(PC_select), .HI_select(HI_select),
    .LO_select(LO_select), .Z_HI_select(Z_HI_select), .Z_LO_select(Z_LO_select),
    .MDR_select(MDR_select), .InPort_select(InPort_select), .c_select(c_select),
    .read(read), .write(write), .alu_instruction(alu_instruction),
    .halted(halted), .illegal_op(illegal_op), .mem_error(mem_error),
    .state_o(state_o)
  );

  assign dut_o = {reg_in_en, reg_out_sel, PC_enable, PC_increment_enable, IR_enable,
                  Y_enable, Z_enable, MAR_enable, MDR_enable, HI_enable, LO_enable,
                  PC_select, HI_select, LO_select, Z_HI_select, Z_LO_select, MDR_select,
                  InPort_select, c_select, read, write, alu_instruction, halted,
                  illegal_op, mem_error};

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic [34:0]  stim_q[$];
  string        tag_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  out_t        e;
  logic        m_err;
  logic        run_v;
  logic [31:0] cur_ir;
  string       cur_tag;

  function automatic logic [15:0] oh(input logic [3:0] r);
    logic [15:0] one;
    one = 16'h0001;
    return one << r;
  endfunction

  // Record one cycle: expected outputs e, inputs (mr=2 means don't-care -> random)
  task automatic push(input int mr = 2, input bit clr_v = 1'b0);
    out_t o;
    logic mrv;
    o = e;
    o.merr = m_err;
    mrv = (mr == 2) ? 1'($urandom_range(0, 1)) : (mr != 0);
    exp_q.push_back(o);
    stim_q.push_back({clr_v, run_v, mrv, cur_ir});
    tag_q.push_back(cur_tag);
    if (clr_v) m_err = 1'b0;
    e = '0;
  endtask

  // Strobe held until mem_ready after 'zeros' idle cycles, or TO cycles then timeout
  task automatic mem_wait(input bit is_wr, input int zeros, output bit tmo);
    tmo = 1'b0;
    for (int k = 0; k < TO; k++) begin
      if (is_wr) e.wr = 1'b1; else e.rd = 1'b1;
      if (k == zeros) begin
        if (!is_wr) e.mdr_en = 1'b1;
        push(1);
        return;
      end
      push(0);
    end
    tmo = 1'b1;
    m_err = 1'b1;
  endtask

  task automatic fetch(input int zeros, output bit tmo);
    e.pc_sel = 1'b1; e.mar_en = 1'b1; e.pc_inc = 1'b1; push();
    mem_wait(1'b0, zeros, tmo);
    if (!tmo) begin
      e.mdr_sel = 1'b1; e.ir_en = 1'b1; push();
    end
  endtask

  task automatic run_instr(input logic [31:0] ir, input int fz, input int dz, output bit stopped);
    logic [4:0] oc;
    logic [3:0] ra, rb, rc;
    bit tmo;
    oc = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    cur_ir = ir;
    stopped = 1'b0;
    fetch(fz, tmo);
    if (tmo) begin stopped = 1'b1; return; end
    if (oc inside {[5'd3:5'd11]}) begin
      e.rout = oh(rb); e.y_en = 1'b1; push();
      e.rout = oh(rc); e.alu = oc; e.z_en = 1'b1; push();
      e.zlo_sel = 1'b1; e.rin = oh(ra); push();
    end else if (oc inside {5'd1, 5'd12, 5'd13, 5'd14}) begin
      e.rout = oh(rb); e.y_en = 1'b1; push();
      e.c_sel = 1'b1; e.z_en = 1'b1;
      e.alu = (oc == 5'd13) ? ANDO : (oc == 5'd14) ? ORO : ADD; push();
      e.zlo_sel = 1'b1; e.rin = oh(ra); push();
    end else if (oc inside {5'd15, 5'd16}) begin
      e.rout = oh(ra); e.y_en = 1'b1; push();
      e.rout = oh(rb); e.alu = oc; e.z_en = 1'b1; push();
      e.zlo_sel = 1'b1; e.lo_en = 1'b1; push();
      e.zhi_sel = 1'b1; e.hi_en = 1'b1; push();
    end else if (oc inside {5'd17, 5'd18}) begin
      e.rout = oh(rb); e.alu = oc; e.z_en = 1'b1; push();
      e.zlo_sel = 1'b1; e.rin = oh(ra); push();
    end else if (oc == 5'd0 || oc == 5'd2) begin
      e.rout = oh(rb); e.y_en = 1'b1; push();
      e.c_sel = 1'b1; e.alu = ADD; e.z_en = 1'b1; push();
      e.zlo_sel = 1'b1; e.mar_en = 1'b1; push();
      if (oc == 5'd0) begin
        mem_wait(1'b0, dz, tmo);
        if (tmo) begin stopped = 1'b1; return; end
        e.mdr_sel = 1'b1; e.rin = oh(ra); push();
      end else begin
        e.rout = oh(ra); e.mdr_en = 1'b1; push();
        mem_wait(1'b1, dz, tmo);
        stopped = tmo;
      end
    end else if (oc == 5'd26) begin
      push();
    end else if (oc == 5'd27) begin
      push();
      stopped = 1'b1;
    end else begin
      e.ill = 1'b1; push();
    end
  endtask

  task automatic halt_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      run_v = 1'($urandom_range(0, 1));
      e.halted = 1'b1; push();
    end
    run_v = 1'b1;
  endtask

  // clr in the final HALT cycle, then idle cycles and a restart
  task automatic clear_and_restart();
    e.halted = 1'b1; push(0, 1'b1);
    run_v = 1'b0; push(); push();
    run_v = 1'b1; push();
  endtask

  function automatic int rand_lat();
    return ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [4:0] oc;
    oc = 5'($urandom_range(0, 31));
    if (oc == 5'd27) oc = 5'd26;
    return {oc, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 15'($urandom_range(0, 32767))};
  endfunction

  // Main: reset check, build program, then run driver and monitor
  initial begin
    bit st;
    clr = 1'b1; run = 1'b0; mem_ready = 1'b0; IR_Data = '0;
    e = '0; m_err = 1'b0; run_v = 1'b0; cur_ir = '0; cur_tag = "idle";
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (dut_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", dut_o, {W{1'b0}});
    end

    run_v = 1'b0; push(); push();
    run_v = 1'b1; push();
    cur_tag = "add_r3_r1_r2"; run_instr(32'h19890000, 2, 0, st);
    cur_tag = "ld_r2_10_r1";  run_instr(32'h01080010, 1, 3, st);
    cur_tag = "st_ok";        run_instr(32'h11100004, 0, 2, st);
    cur_tag = "add_r3_r3_r4"; run_instr(32'h199A0000, 0, 0, st);
    for (int i = 0; i < 30; i++) begin
      cur_tag = "random";
      run_instr(rand_ir(), rand_lat(), rand_lat(), st);
    end
    cur_tag = "illegal";      run_instr(32'hF8000000, 1, 0, st);
    cur_tag = "nop";          run_instr(32'hD0000000, 0, 0, st);
    cur_tag = "after_nop";    run_instr(32'h61880000, 0, 0, st);

    // mul interrupted by clr in T5
    cur_tag = "mul_clr";
    cur_ir = 32'h78A00000;
    fetch(1, st);
    e.rout = oh(4'd1); e.y_en = 1'b1; push();
    e.rout = oh(4'd4); e.alu = 5'b01111; e.z_en = 1'b1; push();
    e.zlo_sel = 1'b1; e.lo_en = 1'b1; push(2, 1'b1);
    run_v = 1'b0; push(); push(); push();
    run_v = 1'b1; push();

    cur_tag = "st_timeout";   run_instr(32'h10880000, 0, TO, st);
    halt_cycles(6);
    cur_tag = "after_clr";    clear_and_restart();
    cur_tag = "ld_boundary";  run_instr(32'h00900008, TO - 1, TO - 1, st);
    cur_tag = "illegal2";     run_instr(32'hF8000000, 0, 0, st);
    cur_tag = "halt";         run_instr(32'hD8000000, 0, 0, st);
    halt_cycles(8);

    @(posedge clk); #1;
    fork
      begin : driver
        logic [34:0] s;
        while (stim_q.size() > 0) begin
          s = stim_q.pop_front();
          {clr, run, mem_ready, IR_Data} = s;
          @(posedge clk); #1;
        end
      end
      begin : monitor
        logic [W-1:0] x;
        string t;
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
          @(negedge clk);
          x = exp_q.pop_front();
          t = tag_q.pop_front();
          n_tests++;
          if (dut_o !== x) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", t, cyc, dut_o, x);
          end
          cyc++;
        end
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
